// File: rtl/dat_mem_dma.sv
// dat_mem_dma: block copy / block fill sequencer and port arbiter for the
// 8-bit, 256-byte data memory. The engine shares the single memory port
// with the core load/store path. The core wins arbitration until it has
// starved the engine for MAX_STALL consecutive active cycles. After that
// the core is denied for exactly one cycle so the engine can advance.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, mode                launch request (IDLE only), 0 = copy / 1 = fill
//   src_addr, dst_addr, len    copy source, destination, byte count (0 = no-op)
//   fill_val                   byte written by a fill
//   busy, done                 operation in progress, one-cycle completion pulse
//   cpu_req, cpu_wr_en         core port request and write enable
//   cpu_addr, cpu_dat_in       core address and write data
//   cpu_gnt, cpu_dat_out       core owns the port this cycle, core read data
//   mem_addr, mem_dat_in       memory address and write data
//   mem_wr_en, mem_dat_out     memory write enable, combinational read data
module dat_mem_dma #(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] src_addr,
  input  logic [7:0] dst_addr,
  input  logic [7:0] len,
  input  logic [7:0] fill_val,
  output logic       busy,
  output logic       done,
  input  logic       cpu_req,
  input  logic       cpu_wr_en,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_dat_in,
  output logic       cpu_gnt,
  output logic [7:0] cpu_dat_out,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_dat_in,
  output logic       mem_wr_en,
  input  logic [7:0] mem_dat_out
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

  localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

  state_t     state, state_nxt;
  logic [7:0] src_ptr, dst_ptr, cnt, data_buf, fill_q;
  logic [3:0] stall_cnt;
  logic       active, eng_own, last_byte;
  logic [7:0] eng_addr, eng_dat;
  logic       eng_we;

  assign active    = (state == S_RD) || (state == S_WR) || (state == S_FILL);
  assign last_byte = (cnt == 8'd1);

  // The grant is gated by rst_n so the core cannot reach the memory while
  // reset is held.
  assign cpu_gnt = rst_n && cpu_req && (!active || (stall_cnt != STALL_LIMIT));
  assign eng_own = active && !cpu_gnt;
  assign cpu_dat_out = mem_dat_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Active states advance only on cycles the engine owns the port.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == 8'd0) ? S_DONE : (mode ? S_FILL : S_RD);
      S_RD:   if (eng_own) state_nxt = S_WR;
      S_WR:   if (eng_own) state_nxt = last_byte ? S_DONE : S_RD;
      S_FILL: if (eng_own) state_nxt = last_byte ? S_DONE : S_FILL;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, pointer and count updates, and the stall counter.
  // The stall counter clears whenever the engine owns the port. Active states
  // are only left on an engine-owned cycle, so it also reads zero on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr   <= 8'd0;
      dst_ptr   <= 8'd0;
      cnt       <= 8'd0;
      data_buf  <= 8'd0;
      fill_q    <= 8'd0;
      stall_cnt <= 4'd0;
    end else begin
      if (active && cpu_gnt) stall_cnt <= stall_cnt + 4'd1;
      else                   stall_cnt <= 4'd0;
      case (state)
        S_IDLE: if (start && (len != 8'd0)) begin
          src_ptr <= src_addr;
          dst_ptr <= dst_addr;
          cnt     <= len;
          fill_q  <= fill_val;
        end
        S_RD: if (eng_own) data_buf <= mem_dat_out;
        S_WR: if (eng_own) begin
          src_ptr <= src_ptr + 8'd1;
          dst_ptr <= dst_ptr + 8'd1;
          cnt     <= cnt - 8'd1;
        end
        S_FILL: if (eng_own) begin
          dst_ptr <= dst_ptr + 8'd1;
          cnt     <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Output logic: engine-side port request, status flags and the port mux.
  always_comb begin
    eng_addr = 8'd0;
    eng_dat  = 8'd0;
    eng_we   = 1'b0;
    case (state)
      S_RD:   eng_addr = src_ptr;
      S_WR:   begin eng_addr = dst_ptr; eng_dat = data_buf; eng_we = 1'b1; end
      S_FILL: begin eng_addr = dst_ptr; eng_dat = fill_q;   eng_we = 1'b1; end
      default: ;
    endcase

    busy = active;
    done = (state == S_DONE);

    mem_addr   = 8'd0;
    mem_dat_in = 8'd0;
    mem_wr_en  = 1'b0;
    if (cpu_gnt) begin
      mem_addr   = cpu_addr;
      mem_dat_in = cpu_dat_in;
      mem_wr_en  = cpu_wr_en;
    end else if (eng_own) begin
      mem_addr   = eng_addr;
      mem_dat_in = eng_dat;
      mem_wr_en  = eng_we;
    end
  end

endmodule

// File: tb/tb_dat_mem_dma.sv
// tb_dat_mem_dma: directed testbench for dat_mem_dma. A behavioural 256-byte
// memory with a combinational read and a posedge write sits on the mem_* port.
// Each scenario task drives stimulus and checks hand-computed expectations.
module tb_dat_mem_dma;

  logic       clk, rst_n;
  logic       start, mode;
  logic [7:0] src_addr, dst_addr, len, fill_val;
  logic       busy, done;
  logic       cpu_req, cpu_wr_en;
  logic [7:0] cpu_addr, cpu_dat_in;
  logic       cpu_gnt;
  logic [7:0] cpu_dat_out;
  logic [7:0] mem_addr, mem_dat_in;
  logic       mem_wr_en;
  logic [7:0] mem_dat_out;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  dat_mem_dma #(.MAX_STALL(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .mode(mode), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_dat_in(cpu_dat_in), .cpu_gnt(cpu_gnt), .cpu_dat_out(cpu_dat_out),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_wr_en(mem_wr_en),
    .mem_dat_out(mem_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory
  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  // Launch an operation: start is held across exactly one sampling edge.
  // On return, the next negedge falls in cycle 1 of the operation.
  task automatic start_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = a; cpu_dat_in = d;
    @(posedge clk);
    #1 cpu_req = 1'b0; cpu_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 8'h55; cpu_dat_in = 8'hAA;
    #1;
    checks++;
    if ({busy, done, mem_wr_en, cpu_gnt, mem_addr} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b we=%b gnt=%b addr=%h, expected all 0",
               busy, done, mem_wr_en, cpu_gnt, mem_addr);
    end
    cpu_req = 1'b0; cpu_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_port;
    cpu_write(8'h14, 8'h5A); cpu_write(8'hFE, 8'h11); cpu_write(8'hFF, 8'h22);
    cpu_write(8'h00, 8'h33); cpu_write(8'h01, 8'h44); cpu_write(8'h02, 8'h55);
    cpu_write(8'h03, 8'h66); cpu_write(8'h80, 8'h99); cpu_write(8'h90, 8'h01);
    cpu_write(8'h63, 8'h00);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'hFF;
    #1;
    checks++;
    if ({cpu_gnt, mem_wr_en, mem_addr, cpu_dat_out} !== {1'b1, 1'b0, 8'hFF, 8'h22}) begin
      errors++;
      $display("[TB] FAIL cpu_read_idle: got gnt=%b we=%b addr=%h data=%h, expected 1 0 ff 22",
               cpu_gnt, mem_wr_en, mem_addr, cpu_dat_out);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_fill;
    logic [10:0] exp_v;
    start_op(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      exp_v = {(k <= 4), (k == 5), (k <= 4), (k <= 4) ? 8'(8'h10 + k - 1) : 8'h00};
      checks++;
      if ({busy, done, mem_wr_en, mem_addr} !== exp_v) begin
        errors++;
        $display("[TB] FAIL fill_cycle%0d: got busy/done/we/addr=%b/%b/%b/%h, expected %b/%b/%b/%h",
                 k, busy, done, mem_wr_en, mem_addr, exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
    for (int a = 8'h10; a <= 8'h13; a++) begin
      checks++;
      if (mem[a] !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL fill_data[%h]: got %h, expected a5", a[7:0], mem[a]);
      end
    end
    checks++;
    if (mem[8'h14] !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL fill_overrun: mem[14] got %h, expected 5a", mem[8'h14]);
    end
  endtask

  task automatic test_copy_wrap;
    int done_cycle, busy_cycles;
    logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    done_cycle = 0; busy_cycles = 0;
    start_op(1'b0, 8'hFE, 8'h40, 8'd3, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (busy) busy_cycles++;
      if (done && done_cycle == 0) done_cycle = k;
    end
    checks++;
    if (done_cycle != 7 || busy_cycles != 6) begin
      errors++;
      $display("[TB] FAIL copy_timing: got done cycle %0d busy cycles %0d, expected 7 and 6",
               done_cycle, busy_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[8'h40 + i] !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL copy_data[%0d]: got %h, expected %h", i, mem[8'h40 + i], exp_d[i]);
      end
    end
  endtask

  task automatic test_stall_bound;
    logic exp_g;
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'h80;
    start_op(1'b1, 8'h00, 8'h70, 8'd2, 8'hC3);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); #1;
      exp_g = (k % 5) != 0;
      checks++;
      if ({cpu_gnt, done} !== {exp_g, (k == 11)}) begin
        errors++;
        $display("[TB] FAIL stall_gnt_cycle%0d: got gnt=%b done=%b, expected %b %b",
                 k, cpu_gnt, done, exp_g, (k == 11));
      end
      checks++;
      if (exp_g && cpu_dat_out !== 8'h99) begin
        errors++;
        $display("[TB] FAIL stall_cpu_read_cycle%0d: got %h, expected 99", k, cpu_dat_out);
      end else if (!exp_g && {mem_wr_en, mem_addr} !== {1'b1, (k == 5) ? 8'h70 : 8'h71}) begin
        errors++;
        $display("[TB] FAIL stall_engine_cycle%0d: got we=%b addr=%h, expected 1 %h",
                 k, mem_wr_en, mem_addr, (k == 5) ? 8'h70 : 8'h71);
      end
    end
    cpu_req = 1'b0;
    checks++;
    if ({mem[8'h70], mem[8'h71]} !== 16'hC3C3) begin
      errors++;
      $display("[TB] FAIL stall_fill_data: got %h %h, expected c3 c3", mem[8'h70], mem[8'h71]);
    end
  endtask

  task automatic test_cpu_write_mid_copy;
    int done_cycle;
    logic [7:0] exp_d [4] = '{8'h33, 8'h44, 8'h77, 8'h66};
    done_cycle = 0;
    start_op(1'b0, 8'h00, 8'h20, 8'd4, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 8'h02; cpu_dat_in = 8'h77; end
      if (k == 2) begin cpu_req = 1'b0; cpu_wr_en = 1'b0; end
      #1;
      if (k == 1) begin
        checks++;
        if ({cpu_gnt, busy, mem_wr_en, mem_addr} !== {3'b111, 8'h02}) begin
          errors++;
          $display("[TB] FAIL midcopy_cpu_gnt: got gnt=%b busy=%b we=%b addr=%h, expected 1 1 1 02",
                   cpu_gnt, busy, mem_wr_en, mem_addr);
        end
      end
      if (done && done_cycle == 0) done_cycle = k;
    end
    checks++;
    if (done_cycle != 10) begin
      errors++;
      $display("[TB] FAIL midcopy_done_cycle: got %0d, expected 10", done_cycle);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h20 + i] !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL midcopy_data[%0d]: got %h, expected %h", i, mem[8'h20 + i], exp_d[i]);
      end
    end
  endtask

  task automatic test_zero_len_and_ignored_start;
    logic we_seen;
    we_seen = 1'b0;
    start_op(1'b0, 8'h00, 8'h50, 8'd0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (mem_wr_en) we_seen = 1'b1;
      checks++;
      if ({busy, done} !== {1'b0, (k == 1)}) begin
        errors++;
        $display("[TB] FAIL zero_len_cycle%0d: got busy=%b done=%b, expected 0 %b", k, busy, done, (k == 1));
      end
    end
    checks++;
    if (we_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_len_write: got wr_en seen=%b, expected 0", we_seen);
    end

    start_op(1'b1, 8'h00, 8'h30, 8'd3, 8'h3C);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b1; mode = 1'b1; dst_addr = 8'h90; len = 8'd5; fill_val = 8'hEE; end
      if (k == 2 || k == 5) start = 1'b0;
      if (k == 4) start = 1'b1;
      #1;
      checks++;
      if ({busy, done} !== {(k <= 3), (k == 4)}) begin
        errors++;
        $display("[TB] FAIL ignored_start_cycle%0d: got busy=%b done=%b, expected %b %b",
                 k, busy, done, (k <= 3), (k == 4));
      end
    end
    checks++;
    if ({mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h90]} !== 32'h3C3C3C01) begin
      errors++;
      $display("[TB] FAIL ignored_start_data: got %h %h %h %h, expected 3c 3c 3c 01",
               mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h90]);
    end
  endtask

  task automatic test_reset_mid_op;
    start_op(1'b1, 8'h00, 8'h60, 8'd8, 8'hAB);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 3) begin
        checks++;
        if ({mem_wr_en, mem_addr} !== {1'b1, 8'h62}) begin
          errors++;
          $display("[TB] FAIL reset_mid_third_write: got we=%b addr=%h, expected 1 62", mem_wr_en, mem_addr);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_wr_en, mem_addr} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got busy=%b done=%b we=%b addr=%h, expected all 0",
               busy, done, mem_wr_en, mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]} !== 32'hABABAB00) begin
      errors++;
      $display("[TB] FAIL reset_mid_data: got %h %h %h %h, expected ab ab ab 00",
               mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]);
    end
    start_op(1'b1, 8'h00, 8'h63, 8'd1, 8'h5D);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({busy, done} !== {(k == 1), (k == 2)}) begin
        errors++;
        $display("[TB] FAIL post_reset_cycle%0d: got busy=%b done=%b, expected %b %b",
                 k, busy, done, (k == 1), (k == 2));
      end
    end
    checks++;
    if (mem[8'h63] !== 8'h5D) begin
      errors++;
      $display("[TB] FAIL post_reset_data: got %h, expected 5d", mem[8'h63]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; len = 8'h00; fill_val = 8'h00;
    cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 8'h00; cpu_dat_in = 8'h00;
    test_reset;
    test_cpu_port;
    test_fill;
    test_copy_wrap;
    test_stall_bound;
    test_cpu_write_mid_copy;
    test_zero_len_and_ignored_start;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dat_mem_dma.md
Name: dat_mem_dma

Overview:
- Sequencer and port arbiter for the 8-bit, 256-byte data memory.
- Runs block copy (src to dst) and block fill operations on the single memory port.
- Shares that port with the core load/store path: the core has priority, and a bounded-stall rule guarantees the engine makes progress.
- Sits between the core's memory interface and the data memory; it is the only driver of the memory's addr, dat_in and wr_en.

Parameters:
- MAX_STALL, 4: consecutive cycles the engine may lose arbitration before it is forced one cycle of ownership. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; sampled with start
- src_addr  in  8  copy source base; sampled with start
- dst_addr  in  8  destination base; sampled with start
- len  in  8  byte count; sampled with start; 0 = no-op
- fill_val  in  8  fill byte; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- cpu_req  in  1  core requests the memory port this cycle
- cpu_wr_en  in  1  core write enable
- cpu_addr  in  8  core address
- cpu_dat_in  in  8  core write data
- cpu_gnt  out  1  core owns the port this cycle (combinational)
- cpu_dat_out  out  8  read data to core; always equals mem_dat_out
- mem_addr  out  8  to memory addr
- mem_dat_in  out  8  to memory dat_in
- mem_wr_en  out  1  to memory wr_en
- mem_dat_out  in  8  from memory dat_out (combinational read)

Behaviour:
- Reset (async, immediate):
  - State IDLE; busy=0, done=0.
  - Stall counter, byte counter, address and data registers all cleared.
  - mem_wr_en=0 and mem_addr=0 while rst_n is low.
  - An operation in flight is abandoned; no partial write completes after reset is asserted.
- States and transitions:
  - IDLE, start=1, len=0: go to DONE; no memory access.
  - IDLE, start=1, len!=0: latch operands; go to RD if mode=0, FILL if mode=1.
  - RD (engine owns port): mem_addr=src ptr, mem_wr_en=0; capture mem_dat_out into buf; go to WR.
  - WR (engine owns port): mem_addr=dst ptr, mem_dat_in=buf, mem_wr_en=1; increment src and dst ptr, decrement count. If count becomes 0 go to DONE, else go to RD.
  - FILL (engine owns port): mem_addr=dst ptr, mem_dat_in=fill_val (latched), mem_wr_en=1; increment dst ptr, decrement count. If count becomes 0 go to DONE, else stay in FILL.
  - DONE: done=1, busy=0 for one cycle; go to IDLE. start is ignored in DONE.
- In any active state (RD/WR/FILL), a cycle the engine loses arbitration holds state, pointers, count and buf unchanged.
- busy=1 in RD, WR and FILL only.
- Throughput with no contention:
  - Copy: 2 cycles per byte.
  - Fill: 1 cycle per byte.
  - len=N copy: done asserts 2N+1 cycles after the start sample edge.
- Address arithmetic is 8-bit modulo 256; pointers wrap from 0xFF to 0x00.
- Copy is strictly ascending. Overlapping ranges with dst>src propagate data forward; this is defined behaviour, not an error.
- Arbitration:
  - In IDLE or DONE: cpu_gnt = cpu_req.
  - In an active state: cpu_gnt = cpu_req && (stall_cnt != MAX_STALL).
  - stall_cnt increments each active cycle the engine loses, and clears on any cycle the engine owns the port or when leaving active states.
  - Once stall_cnt reaches MAX_STALL, the core is denied for exactly one cycle, the engine advances, and the counter clears.
- Port mux:
  - cpu_gnt=1: mem_* driven from cpu_*.
  - Else if the engine owns the port: mem_* driven from the engine.
  - Else: mem_addr=0, mem_dat_in=0, mem_wr_en=0.
- The core must hold cpu_req and its operands until it sees cpu_gnt=1. A core read is valid on cpu_dat_out in the grant cycle; a core write commits at the edge ending the grant cycle.
- start while busy, or in DONE, is ignored and has no side effects.

Test Plan:
- Fill: mode=1, dst=0x10, len=4, fill_val=0xA5, no cpu_req -> bytes 0x10..0x13 = 0xA5; busy high 4 cycles; done pulses on cycle 5; 0x14 unchanged.
- Copy with wrap: preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33; src=0xFE, dst=0x40, len=3 -> 0x40..0x42 = 0x11, 0x22, 0x33; done 7 cycles after start.
- Stall bound: MAX_STALL=4, fill len=2, cpu_req held high with reads of 0x80 -> cpu_gnt low on every 5th active cycle; fill completes; core reads return correct data on granted cycles.
- Core write mid-copy: copy 0x00 to 0x20, len=4; core writes 0x02=0x77 before the engine reads 0x02 -> 0x22 = 0x77.
- Zero length and ignored start: len=0 -> done pulses one cycle after start, mem_wr_en never asserts. A second start during busy -> no effect on the running operation.
- Reset mid-op: fill len=8, deassert rst_n after 3 writes -> mem_wr_en=0, busy=0 immediately; only 3 bytes modified; the next start runs normally.
